// File: rtl/picorv32_sram_pkg.sv
// Shared types and constants for the PicoRV32 SRAM controller.
package picorv32_sram_pkg;

    localparam int WSTRB_W = 4;
    localparam int DATA_W  = 32;

    localparam logic [DATA_W-1:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/picorv32_sram_ctrl_if.sv
// PicoRV32 native memory bus; the CPU is the master, the controller the slave.
interface picorv32_sram_ctrl_if;
    import picorv32_sram_pkg::*;

    logic               mem_valid;
    logic               mem_instr;
    logic [31:0]        mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [WSTRB_W-1:0] mem_wstrb;
    logic               mem_ready;
    logic [DATA_W-1:0]  mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_sram_ctrl_addr_decode.sv
// Window decode: in-range flag and SRAM word address from a CPU byte address.
module sram_addr_decode #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic [31:0]           addr,
    output logic                  in_range,
    output logic [ADDR_WIDTH-1:0] word_addr
);
    logic unused_byte_off;

    assign in_range        = (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign word_addr       = addr[ADDR_WIDTH+1:2];
    assign unused_byte_off = ^addr[1:0];
endmodule

// File: rtl/picorv32_sram_ctrl.sv
// PicoRV32 memory-side controller driving a single-port synchronous SRAM macro.
// Every output is a flop; the FSM serialises one access at a time.
module picorv32_sram_ctrl
    import picorv32_sram_pkg::*;
#(
    parameter int                ADDR_WIDTH   = 8,
    parameter logic [31:0]       BASE_ADDR    = 32'h0000_0000,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] ERR_RDATA    = DEF_ERR_RDATA
) (
    input  logic                    clk,
    input  logic                    reset,
    picorv32_sram_ctrl_if.slave     bus,
    output logic                    sram_csb,
    output logic                    sram_web,
    output logic [WSTRB_W-1:0]      sram_wmask,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_W-1:0]       sram_din,
    input  logic [DATA_W-1:0]       sram_dout,
    input  logic                    err_clr,
    output logic                    bus_err
);
    state_e                state_q, state_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic                  sram_csb_q, sram_csb_d;
    logic                  sram_web_q, sram_web_d;
    logic [WSTRB_W-1:0]    sram_wmask_q, sram_wmask_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]     sram_din_q, sram_din_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;
    logic                  bus_err_q, bus_err_d;

    logic                  in_range;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  unused_instr;

    sram_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_dec (
        .addr      (bus.mem_addr),
        .in_range  (in_range),
        .word_addr (word_addr)
    );

    assign unused_instr = bus.mem_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            sram_csb_q   <= 1'b1;
            sram_web_q   <= 1'b1;
            sram_wmask_q <= '0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            sram_csb_q   <= sram_csb_d;
            sram_web_q   <= sram_web_d;
            sram_wmask_q <= sram_wmask_d;
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
            mem_ready_q  <= mem_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.mem_valid) state_d = in_range ? ACCESS : RESP;
            ACCESS:  state_d = sram_web_q ? WAIT : RESP;
            WAIT:    if (lat_cnt_q == 2'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lat_cnt_d    = lat_cnt_q;
        sram_csb_d   = sram_csb_q;
        sram_web_d   = sram_web_q;
        sram_wmask_d = sram_wmask_q;
        sram_addr_d  = sram_addr_q;
        sram_din_d   = sram_din_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        // A new error in the same cycle as err_clr must leave the flag set.
        bus_err_d    = err_clr ? 1'b0 : bus_err_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_valid && in_range) begin
                    sram_csb_d   = 1'b0;
                    sram_web_d   = (bus.mem_wstrb == '0);
                    sram_wmask_d = bus.mem_wstrb;
                    sram_addr_d  = word_addr;
                    sram_din_d   = bus.mem_wdata;
                end else if (bus.mem_valid) begin
                    mem_rdata_d  = ERR_RDATA;
                    mem_ready_d  = 1'b1;
                    bus_err_d    = 1'b1;
                end
            end
            ACCESS: begin
                sram_csb_d   = 1'b1;
                sram_web_d   = 1'b1;
                sram_wmask_d = '0;
                if (!sram_web_q) mem_ready_d = 1'b1;
                else             lat_cnt_d   = 2'(READ_LATENCY - 1);
            end
            WAIT: begin
                if (lat_cnt_q == 2'd0) begin
                    mem_rdata_d = sram_dout;
                    mem_ready_d = 1'b1;
                end else begin
                    lat_cnt_d   = lat_cnt_q - 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign sram_csb      = sram_csb_q;
    assign sram_web      = sram_web_q;
    assign sram_wmask    = sram_wmask_q;
    assign sram_addr     = sram_addr_q;
    assign sram_din      = sram_din_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus_err       = bus_err_q;
endmodule

// File: tb/tb_picorv32_sram_ctrl.sv
// Directed bench: READ_LATENCY=1 and =3 controllers share one stimulus stream,
// each with a behavioural SRAM that returns rd_pat only on its valid-data cycle.
module tb_picorv32_sram_ctrl;
    import picorv32_sram_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic err_clr;
    logic [31:0] rd_pat;

    always #5 clk = ~clk;

    picorv32_sram_ctrl_if if1 ();
    picorv32_sram_ctrl_if if3 ();

    assign if3.mem_valid = if1.mem_valid;
    assign if3.mem_instr = if1.mem_instr;
    assign if3.mem_addr  = if1.mem_addr;
    assign if3.mem_wdata = if1.mem_wdata;
    assign if3.mem_wstrb = if1.mem_wstrb;

    logic        csb1, web1, csb3, web3, err1, err3;
    logic [3:0]  wmask1, wmask3;
    logic [7:0]  addr1, addr3;
    logic [31:0] din1, din3, dout1, dout3;

    picorv32_sram_ctrl #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .sram_csb(csb1), .sram_web(web1), .sram_wmask(wmask1), .sram_addr(addr1),
        .sram_din(din1), .sram_dout(dout1), .err_clr(err_clr), .bus_err(err1)
    );

    picorv32_sram_ctrl #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave),
        .sram_csb(csb3), .sram_web(web3), .sram_wmask(wmask3), .sram_addr(addr3),
        .sram_din(din3), .sram_dout(dout3), .err_clr(err_clr), .bus_err(err3)
    );

    logic [31:0] mem1 [256];
    logic [31:0] p1;
    logic [31:0] p3 [3];
    int csb_lo1 = 0;
    int rdy1    = 0;

    always @(posedge clk) begin
        if (!csb1 && !web1)
            for (int b = 0; b < 4; b++)
                if (wmask1[b]) mem1[addr1][b*8 +: 8] <= din1[b*8 +: 8];
        p1    <= (!csb1 && web1) ? rd_pat : 32'h0BAD_0BAD;
        p3[0] <= (!csb3 && web3) ? rd_pat : 32'h0BAD_0BAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (!csb1)         csb_lo1 <= csb_lo1 + 1;
        if (if1.mem_ready) rdy1    <= rdy1 + 1;
    end

    assign dout1 = p1;
    assign dout3 = p3[2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if1.mem_valid = 1'b1;
        if1.mem_instr = (s == 4'h0);
        if1.mem_addr  = a;
        if1.mem_wdata = d;
        if1.mem_wstrb = s;
    endtask

    int c0, r0;

    initial begin
        for (int i = 0; i < 256; i++) mem1[i] = '0;
        reset = 1'b1;
        err_clr = 1'b0;
        rd_pat = 32'h0;
        if1.mem_valid = 1'b0;
        if1.mem_instr = 1'b0;
        if1.mem_addr  = '0;
        if1.mem_wdata = '0;
        if1.mem_wstrb = '0;
        tick(); tick();

        chk("rst csb",   csb1, 1);
        chk("rst web",   web1, 1);
        chk("rst wmask", wmask1, 0);
        chk("rst addr",  addr1, 0);
        chk("rst din",   din1, 0);
        chk("rst ready", if1.mem_ready, 0);
        chk("rst rdata", if1.mem_rdata, 0);
        chk("rst err",   err1, 0);
        reset = 1'b0;
        c0 = csb_lo1;
        repeat (10) tick();
        chk("idle csb cnt", csb_lo1 - c0, 0);
        chk("idle csb", csb1, 1);

        // Write: csb low in T1, ready in T2 only
        req(32'h10, 32'hA5A5_1234, 4'b0011);
        tick();
        chk("wr T1 csb",   csb1, 0);
        chk("wr T1 web",   web1, 0);
        chk("wr T1 addr",  addr1, 4);
        chk("wr T1 wmask", wmask1, 4'b0011);
        chk("wr T1 din",   din1, 32'hA5A5_1234);
        chk("wr T1 ready", if1.mem_ready, 0);
        if1.mem_valid = 1'b0;
        if1.mem_addr  = 32'h44;
        tick();
        chk("wr T2 ready", if1.mem_ready, 1);
        chk("wr T2 csb",   csb1, 1);
        chk("wr T2 web",   web1, 1);
        chk("wr T2 wmask", wmask1, 0);
        tick();
        chk("wr T3 ready", if1.mem_ready, 0);
        chk("wr mem",      mem1[4], 32'h0000_1234);

        // Read: RL=1 ready in T3, RL=3 ready in T5
        rd_pat = 32'hCAFE_F00D;
        req(32'h10, 32'h0, 4'h0);
        tick();
        chk("rd T1 csb1", csb1, 0);
        chk("rd T1 web1", web1, 1);
        chk("rd T1 csb3", csb3, 0);
        if1.mem_valid = 1'b0;
        for (int t = 2; t <= 6; t++) begin
            tick();
            chk($sformatf("rd T%0d ready1", t), if1.mem_ready, (t == 3));
            chk($sformatf("rd T%0d ready3", t), if3.mem_ready, (t == 5));
            if (t == 3) chk("rd rdata1", if1.mem_rdata, 32'hCAFE_F00D);
            if (t == 5) chk("rd rdata3", if3.mem_rdata, 32'hCAFE_F00D);
        end
        chk("rd rdata1 hold", if1.mem_rdata, 32'hCAFE_F00D);

        // Out of window: ready in T1, no SRAM access, sticky error
        c0 = csb_lo1;
        req(32'h0000_0400, 32'h0, 4'h0);
        tick();
        chk("oow T1 ready", if1.mem_ready, 1);
        chk("oow T1 rdata", if1.mem_rdata, 32'hDEAD_BEEF);
        chk("oow T1 err",   err1, 1);
        chk("oow T1 csb",   csb1, 1);
        if1.mem_valid = 1'b0;
        tick();
        chk("oow T2 ready", if1.mem_ready, 0);
        chk("oow T2 err",   err1, 1);
        chk("oow csb cnt",  csb_lo1 - c0, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr alone", err1, 0);
        req(32'h0000_0404, 32'h1, 4'hF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        if1.mem_valid = 1'b0;
        chk("err set wins", err1, 1);
        chk("oow wr rdata", if1.mem_rdata, 32'hDEAD_BEEF);
        tick();
        chk("err stays", err1, 1);

        // Back-to-back write then read with mem_valid held high
        rd_pat = 32'h1234_5678;
        c0 = csb_lo1;
        r0 = rdy1;
        req(32'h20, 32'h1111_2222, 4'hF);
        tick();
        tick();
        chk("b2b wr ready", if1.mem_ready, 1);
        req(32'h20, 32'h0, 4'h0);
        tick();
        chk("b2b gap csb", csb1, 1);
        tick();
        chk("b2b rd csb",  csb1, 0);
        chk("b2b rd web",  web1, 1);
        chk("b2b rd addr", addr1, 8);
        tick();
        tick();
        chk("b2b rd ready", if1.mem_ready, 1);
        chk("b2b rd rdata", if1.mem_rdata, 32'h1234_5678);
        if1.mem_valid = 1'b0;
        tick();
        chk("b2b csb pulses",   csb_lo1 - c0, 2);
        chk("b2b ready pulses", rdy1 - r0, 2);
        chk("b2b wr mem",       mem1[8], 32'h1111_2222);
        repeat (4) tick();

        // Reset during WAIT aborts with no ready
        r0 = rdy1;
        req(32'h10, 32'h0, 4'h0);
        tick();
        if1.mem_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw csb",   csb1, 1);
        chk("rstw ready", if1.mem_ready, 0);
        repeat (4) tick();
        chk("rstw no ready", rdy1 - r0, 0);
        chk("rstw err clr",  err1, 0);
        rd_pat = 32'h0F0F_0F0F;
        req(32'h10, 32'h0, 4'h0);
        tick();
        if1.mem_valid = 1'b0;
        chk("post csb", csb1, 0);
        tick();
        tick();
        chk("post ready", if1.mem_ready, 1);
        chk("post rdata", if1.mem_rdata, 32'h0F0F_0F0F);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
